// File: rtl/serial_sub16.sv
// serial_sub16: bit-serial two's-complement subtractor (in0 - in1), LSB first.
// One full-adder slice is reused across WIDTH clocks. Operands are shifted
// right through it, and the sum bits enter the result register at the MSB end.
//
// Optional build macro SERIAL_SUB_ADD_MODE_EN adds an input 'op'
// (0 = subtract, 1 = add). The value of op is latched together with the operands.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// SHIFT | one result bit per clock, WIDTH clocks
// DONE  | result held, out_valid=1, waiting for out_ready
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             add_mode;

  logic             b_bit;
  logic             sum_bit;
  logic             carry_next;

  // Handshake flags depend only on the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef SERIAL_SUB_ADD_MODE_EN
  // Latch the operation mode when the operands are accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_mode <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      add_mode <= op;
    end
  end
`else
  assign add_mode = 1'b0;
`endif

  // Full-adder slice. The subtrahend bit is inverted unless add mode is selected.
  always_comb begin
    b_bit      = add_mode ? b_sr[0] : ~b_sr[0];
    sum_bit    = a_sr[0] ^ b_bit ^ carry;
    carry_next = (a_sr[0] & b_bit) | (a_sr[0] & carry) | (b_bit & carry);
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      count      <= '0;
      carry      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= in0;
            b_sr  <= in1;
            res   <= '0;
            count <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            carry <= ~op;
`else
            carry <= 1'b1;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          res   <= {sum_bit, res[WIDTH-1:1]};
          carry <= carry_next;
          count <= count + CNT_W'(1);
          if (count == LAST_BIT) begin
            // On the last bit, 'carry' still holds the carry into the MSB.
            diff       <= {sum_bit, res[WIDTH-1:1]};
            borrow_out <= add_mode ? carry_next : ~carry_next;
            ovf        <= carry ^ carry_next;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub16.sv
// Directed testbench for serial_sub16. Expected values are computed by hand.
module tb_serial_sub16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        ovf;

  int checks = 0;
  int passes = 0;

  serial_sub16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in0        (in0),
    .in1        (in1),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op         (op),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand pair and wait for out_valid. Returns the number of
  // edges from the accepting edge and the sampled outputs.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic op_v,
                        output int lat, output logic [15:0] d, output logic bo,
                        output logic ov);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_valid = 1'b1; in0 = x; in1 = y; op = op_v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    d = diff; bo = borrow_out; ov = ovf;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0; op = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
    checks++; if (diff !== 16'h0000) $display("FAIL reset_diff got %h exp 0000", diff); else passes++;
    checks++; if (borrow_out !== 1'b0) $display("FAIL reset_borrow got %b exp 0", borrow_out); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_subtract(input string name, input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] ed, input logic eb, input logic eo);
    int lat; logic [15:0] d; logic bo, ov;
    run_op(x, y, 1'b0, lat, d, bo, ov);
    checks++; if (lat != 16) $display("FAIL %s_latency got %0d exp 16", name, lat); else passes++;
    checks++; if (d !== ed) $display("FAIL %s_diff got %h exp %h", name, d, ed); else passes++;
    checks++; if (bo !== eb) $display("FAIL %s_borrow got %b exp %b", name, bo, eb); else passes++;
    checks++; if (ov !== eo) $display("FAIL %s_ovf got %b exp %b", name, ov, eo); else passes++;
    release_result();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL %s_release got in_ready=%b out_valid=%b exp 1/0", name, in_ready, out_valid);
    else passes++;
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] d; logic bo, ov;
    run_op(16'h8000, 16'h0001, 1'b0, lat, d, bo, ov);
    checks++; if (d !== 16'h7FFF) $display("FAIL bp_first_diff got %h exp 7fff", d); else passes++;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in0 = 16'h1000 + 16'(i); in1 = 16'h0F00 - 16'(i);
      @(posedge clk); #1;
      checks++; if (diff !== 16'h7FFF || borrow_out !== 1'b0 || ovf !== 1'b1)
        $display("FAIL bp_hold%0d got %h/%b/%b exp 7fff/0/1", i, diff, borrow_out, ovf);
      else passes++;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_flags%0d got in_ready=%b out_valid=%b exp 0/1", i, in_ready, out_valid);
      else passes++;
    end
    in0 = 16'h0100; in1 = 16'h0001;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_next_accept got in_ready=%b exp 0", in_ready); else passes++;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat != 16) $display("FAIL bp_next_latency got %0d exp 16", lat); else passes++;
    checks++; if (diff !== 16'h00FF || borrow_out !== 1'b0 || ovf !== 1'b0)
      $display("FAIL bp_next_result got %h/%b/%b exp 00ff/0/0", diff, borrow_out, ovf);
    else passes++;
    release_result();
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [15:0] d; logic bo, ov;
    in_valid = 1'b1; in0 = 16'h1111; in1 = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0000)
      $display("FAIL midrst_immediate got in_ready=%b out_valid=%b diff=%h exp 1/0/0000",
               in_ready, out_valid, diff);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    checks++; if (lat != 0) $display("FAIL midrst_no_result got %0d valid cycles exp 0", lat); else passes++;
    run_op(16'h0010, 16'h0001, 1'b0, lat, d, bo, ov);
    checks++; if (lat != 16) $display("FAIL midrst_fresh_latency got %0d exp 16", lat); else passes++;
    checks++; if (d !== 16'h000F || bo !== 1'b0 || ov !== 1'b0)
      $display("FAIL midrst_fresh_result got %h/%b/%b exp 000f/0/0", d, bo, ov);
    else passes++;
    release_result();
  endtask

`ifdef SERIAL_SUB_ADD_MODE_EN
  task automatic test_add_mode();
    int lat; logic [15:0] d; logic bo, ov;
    run_op(16'hFFFF, 16'h0001, 1'b1, lat, d, bo, ov);
    checks++; if (d !== 16'h0000 || bo !== 1'b1 || ov !== 1'b0)
      $display("FAIL add_wrap got %h/%b/%b exp 0000/1/0", d, bo, ov);
    else passes++;
    release_result();
    run_op(16'h7FFF, 16'h0001, 1'b1, lat, d, bo, ov);
    checks++; if (d !== 16'h8000 || bo !== 1'b0 || ov !== 1'b1)
      $display("FAIL add_ovf got %h/%b/%b exp 8000/0/1", d, bo, ov);
    else passes++;
    release_result();
  endtask
`endif

  initial begin
    test_reset();
    test_subtract("sub_5_3", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    test_subtract("sub_3_5", 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
    test_subtract("sub_ovf", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    test_subtract("sub_eq", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
    test_backpressure();
    test_reset_mid_op();
`ifdef SERIAL_SUB_ADD_MODE_EN
    test_add_mode();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
